// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-lane masked stores, lane-aligned loads and an
// optional wait-state sequencer that holds the pipeline through MemStall.
module data_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ReadEn,
    input  logic                  WriteEn,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] MemAddress,
    input  logic [DATA_WIDTH-1:0] MemStoreData,
    output logic [DATA_WIDTH-1:0] MemLoadData,
    output logic                  MemStall,
    output logic                  MemFault
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  access;
    logic                  isStore;
    logic                  fault;
    logic                  complete;
    logic [AW-1:0]         wordIdx;
    logic [1:0]            offset;
    logic [3:0]            byteEn;
    logic [DATA_WIDTH-1:0] storeAligned;
    logic [DATA_WIDTH-1:0] loadShifted;
    logic                  unusedAddrBits;

    // Gating with rst_n keeps every output and the array quiet while reset is held.
    assign access         = rst_n & (ReadEn | WriteEn);
    assign isStore        = WriteEn;
    assign wordIdx        = MemAddress[AW+1:2];
    assign offset         = MemAddress[1:0];
    assign unusedAddrBits = ^MemAddress[DATA_WIDTH-1:AW+2];

    always_comb begin
        fault = 1'b0;
        if (access) begin
            case (Funct3)
                3'b000, 3'b100: fault = 1'b0;
                3'b001, 3'b101: fault = offset[0];
                3'b010:         fault = (offset != 2'b00);
                default:        fault = 1'b1;
            endcase
            if (isStore && Funct3[2]) begin
                fault = 1'b1;
            end
        end
    end

    // A faulting or absent request always lands the sequencer back in IDLE.
    always_comb begin
        state_d  = IDLE;
        cnt_d    = 4'd0;
        MemStall = 1'b0;
        complete = 1'b0;
        if (access && !fault) begin
            if (LATENCY == 0) begin
                complete = 1'b1;
            end else if (state_q == IDLE) begin
                MemStall = 1'b1;
                state_d  = WAIT;
                cnt_d    = CNT_INIT;
            end else if (cnt_q != 4'd0) begin
                MemStall = 1'b1;
                state_d  = WAIT;
                cnt_d    = cnt_q - 4'd1;
            end else begin
                complete = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        storeAligned = MemStoreData << {offset, 3'b000};
        case (Funct3[1:0])
            2'b00:   byteEn = 4'b0001 << offset;
            2'b01:   byteEn = 4'b0011 << offset;
            default: byteEn = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (complete && isStore) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    mem_q[wordIdx][8*b +: 8] <= storeAligned[8*b +: 8];
                end
            end
        end
    end

    assign loadShifted = mem_q[wordIdx] >> {offset, 3'b000};

    always_comb begin
        MemLoadData = '0;
        if (complete && !isStore) begin
            case (Funct3[1:0])
                2'b00:   MemLoadData = {{(DATA_WIDTH-8){1'b0}}, loadShifted[7:0]};
                2'b01:   MemLoadData = {{(DATA_WIDTH-16){1'b0}}, loadShifted[15:0]};
                default: MemLoadData = loadShifted;
            endcase
        end
    end

    assign MemFault = fault;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one single-cycle instance and one
// three-wait-state instance share the same request inputs.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ReadEn;
    logic        WriteEn;
    logic [2:0]  Funct3;
    logic [31:0] MemAddress;
    logic [31:0] MemStoreData;
    logic [31:0] load0, load3;
    logic        stall0, stall3, fault0, fault3;
    int          checks = 0;
    int          failures = 0;

    localparam logic [2:0] F_B   = 3'b000;
    localparam logic [2:0] F_H   = 3'b001;
    localparam logic [2:0] F_W   = 3'b010;
    localparam logic [2:0] F_BAD = 3'b011;
    localparam logic [2:0] F_BU  = 3'b100;
    localparam logic [2:0] F_HU  = 3'b101;

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_WIDTH(32), .DEPTH(1024), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ReadEn(ReadEn), .WriteEn(WriteEn), .Funct3(Funct3),
        .MemAddress(MemAddress), .MemStoreData(MemStoreData),
        .MemLoadData(load0), .MemStall(stall0), .MemFault(fault0)
    );

    data_mem_responder #(.DATA_WIDTH(32), .DEPTH(1024), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ReadEn(ReadEn), .WriteEn(WriteEn), .Funct3(Funct3),
        .MemAddress(MemAddress), .MemStoreData(MemStoreData),
        .MemLoadData(load3), .MemStall(stall3), .MemFault(fault3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic re, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] data);
        ReadEn       = re;
        WriteEn      = we;
        Funct3       = f3;
        MemAddress   = addr;
        MemStoreData = data;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, F_W, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, F_BAD, 32'h4, 32'h0);
        #2;
        checks++;
        if (fault0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_fault0 got=%b exp=0", fault0); end
        checks++;
        if (fault3 !== 1'b0) begin failures++; $display("[TB] FAIL reset_fault3 got=%b exp=0", fault3); end
        applyStimulus(1'b1, 1'b0, F_W, 32'h0, 32'h0);
        #1;
        checks++;
        if (stall3 !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall3 got=%b exp=0", stall3); end
        checks++;
        if (load0 !== 32'h0) begin failures++; $display("[TB] FAIL reset_load0 got=%h exp=00000000", load0); end
        idle();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lat0_word();
        applyStimulus(1'b0, 1'b1, F_W, 32'h10, 32'hDEADBEEF);
        #2;
        checks++;
        if (stall0 !== 1'b0) begin failures++; $display("[TB] FAIL lat0_sw_stall got=%b exp=0", stall0); end
        step();
        applyStimulus(1'b1, 1'b0, F_W, 32'h10, 32'h0);
        #2;
        checks++;
        if (load0 !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL lat0_lw got=%h exp=deadbeef", load0); end
        checks++;
        if (stall0 !== 1'b0) begin failures++; $display("[TB] FAIL lat0_lw_stall got=%b exp=0", stall0); end
        step();
        idle();
        #2;
        checks++;
        if (load0 !== 32'h0) begin failures++; $display("[TB] FAIL lat0_idle_data got=%h exp=00000000", load0); end
        step();
    endtask

    task automatic test_byte_lanes();
        applyStimulus(1'b0, 1'b1, F_W, 32'h20, 32'h11223344);
        step();
        applyStimulus(1'b0, 1'b1, F_B, 32'h22, 32'h123456AA);
        step();
        applyStimulus(1'b1, 1'b0, F_W, 32'h20, 32'h0);
        #2;
        checks++;
        if (load0 !== 32'h11AA3344) begin failures++; $display("[TB] FAIL sb_lw got=%h exp=11aa3344", load0); end
        step();
        applyStimulus(1'b1, 1'b0, F_BU, 32'h23, 32'h0);
        #2;
        checks++;
        if (load0 !== 32'h00000011) begin failures++; $display("[TB] FAIL lbu_23 got=%h exp=00000011", load0); end
        step();
        applyStimulus(1'b1, 1'b0, F_HU, 32'h22, 32'h0);
        #2;
        checks++;
        if (load0 !== 32'h000011AA) begin failures++; $display("[TB] FAIL lhu_22 got=%h exp=000011aa", load0); end
        step();
        applyStimulus(1'b1, 1'b0, F_B, 32'h21, 32'h0);
        #2;
        checks++;
        if (load0 !== 32'h00000033) begin failures++; $display("[TB] FAIL lb_21 got=%h exp=00000033", load0); end
        step();
        applyStimulus(1'b0, 1'b1, F_H, 32'h22, 32'h9999BEEF);
        step();
        applyStimulus(1'b1, 1'b0, F_W, 32'h20, 32'h0);
        #2;
        checks++;
        if (load0 !== 32'hBEEF3344) begin failures++; $display("[TB] FAIL sh_lw got=%h exp=beef3344", load0); end
        step();
        applyStimulus(1'b1, 1'b0, F_H, 32'h22, 32'h0);
        #2;
        checks++;
        if (load0 !== 32'h0000BEEF) begin failures++; $display("[TB] FAIL lh_22 got=%h exp=0000beef", load0); end
        step();
        idle();
        step();
    endtask

    task automatic test_wait_states();
        applyStimulus(1'b0, 1'b1, F_W, 32'h40, 32'hCAFEF00D);
        for (int c = 1; c <= 4; c++) begin
            #2;
            checks++;
            if (stall3 !== ((c < 4) ? 1'b1 : 1'b0)) begin
                failures++; $display("[TB] FAIL sw_wait_stall cycle=%0d got=%b", c, stall3);
            end
            step();
        end
        applyStimulus(1'b1, 1'b0, F_W, 32'h40, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            #2;
            checks++;
            if (stall3 !== ((c < 4) ? 1'b1 : 1'b0)) begin
                failures++; $display("[TB] FAIL lw_wait_stall cycle=%0d got=%b", c, stall3);
            end
            checks++;
            if (load3 !== ((c < 4) ? 32'h0 : 32'hCAFEF00D)) begin
                failures++; $display("[TB] FAIL lw_wait_data cycle=%0d got=%h", c, load3);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 1'b0, F_W, 32'h40, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            #2;
            checks++;
            if (stall3 !== ((c < 4) ? 1'b1 : 1'b0)) begin
                failures++; $display("[TB] FAIL b2b_stall cycle=%0d got=%b", c, stall3);
            end
            checks++;
            if (load3 !== ((c < 4) ? 32'h0 : 32'hCAFEF00D)) begin
                failures++; $display("[TB] FAIL b2b_data cycle=%0d got=%h", c, load3);
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_faults();
        applyStimulus(1'b0, 1'b1, F_H, 32'h41, 32'h0000FFFF);
        #2;
        checks++;
        if (fault3 !== 1'b1) begin failures++; $display("[TB] FAIL sh41_fault got=%b exp=1", fault3); end
        checks++;
        if (stall3 !== 1'b0) begin failures++; $display("[TB] FAIL sh41_stall got=%b exp=0", stall3); end
        checks++;
        if (fault0 !== 1'b1) begin failures++; $display("[TB] FAIL sh41_fault0 got=%b exp=1", fault0); end
        step();
        applyStimulus(1'b1, 1'b0, F_W, 32'h42, 32'h0);
        #2;
        checks++;
        if (fault3 !== 1'b1) begin failures++; $display("[TB] FAIL lw42_fault got=%b exp=1", fault3); end
        checks++;
        if (load0 !== 32'h0) begin failures++; $display("[TB] FAIL lw42_data got=%h exp=00000000", load0); end
        step();
        applyStimulus(1'b1, 1'b0, F_BAD, 32'h40, 32'h0);
        #2;
        checks++;
        if (fault0 !== 1'b1) begin failures++; $display("[TB] FAIL f011_fault got=%b exp=1", fault0); end
        checks++;
        if (load0 !== 32'h0) begin failures++; $display("[TB] FAIL f011_data got=%h exp=00000000", load0); end
        step();
        applyStimulus(1'b0, 1'b1, F_BU, 32'h40, 32'h000000FF);
        #2;
        checks++;
        if (fault0 !== 1'b1) begin failures++; $display("[TB] FAIL sbu_fault got=%b exp=1", fault0); end
        step();
        applyStimulus(1'b1, 1'b0, F_W, 32'h40, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            #2;
            if (c == 1) begin
                checks++;
                if (load0 !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL fault_nowrite0 got=%h exp=cafef00d", load0); end
                checks++;
                if (fault0 !== 1'b0) begin failures++; $display("[TB] FAIL lw40_fault got=%b exp=0", fault0); end
            end
            if (c == 4) begin
                checks++;
                if (load3 !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL fault_nowrite3 got=%h exp=cafef00d", load3); end
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_abort_reset();
        applyStimulus(1'b0, 1'b1, F_W, 32'h50, 32'h0BADF00D);
        repeat (4) step();
        idle();
        step();
        applyStimulus(1'b0, 1'b1, F_W, 32'h50, 32'h12345678);
        #2;
        checks++;
        if (stall3 !== 1'b1) begin failures++; $display("[TB] FAIL abort_stall1 got=%b exp=1", stall3); end
        step();
        idle();
        #2;
        checks++;
        if (stall3 !== 1'b0) begin failures++; $display("[TB] FAIL abort_drop_stall got=%b exp=0", stall3); end
        step();
        step();
        applyStimulus(1'b0, 1'b1, F_W, 32'h50, 32'h12345678);
        #2;
        checks++;
        if (stall3 !== 1'b1) begin failures++; $display("[TB] FAIL rst_stall1 got=%b exp=1", stall3); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall3 !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_stall got=%b exp=0", stall3); end
        idle();
        step();
        rst_n = 1'b1;
        step();
        applyStimulus(1'b1, 1'b0, F_W, 32'h50, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            #2;
            if (c == 4) begin
                checks++;
                if (load3 !== 32'h0BADF00D) begin failures++; $display("[TB] FAIL abort_nowrite got=%h exp=0badf00d", load3); end
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_wrap_collision();
        applyStimulus(1'b0, 1'b1, F_W, 32'h1000, 32'h0000BEEF);
        step();
        applyStimulus(1'b1, 1'b0, F_W, 32'h0, 32'h0);
        #2;
        checks++;
        if (load0 !== 32'h0000BEEF) begin failures++; $display("[TB] FAIL wrap_lw got=%h exp=0000beef", load0); end
        step();
        applyStimulus(1'b1, 1'b1, F_W, 32'h60, 32'h55AA55AA);
        #2;
        checks++;
        if (load0 !== 32'h0) begin failures++; $display("[TB] FAIL collide_data got=%h exp=00000000", load0); end
        checks++;
        if (fault0 !== 1'b0) begin failures++; $display("[TB] FAIL collide_fault got=%b exp=0", fault0); end
        step();
        applyStimulus(1'b1, 1'b0, F_W, 32'h60, 32'h0);
        #2;
        checks++;
        if (load0 !== 32'h55AA55AA) begin failures++; $display("[TB] FAIL collide_store got=%h exp=55aa55aa", load0); end
        step();
        idle();
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        test_reset();
        test_lat0_word();
        test_byte_lanes();
        test_wait_states();
        test_back_to_back();
        test_faults();
        test_abort_reset();
        test_wrap_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
